// File: rtl/calculadora_rpn_pilha.sv
// RPN calculator with a LIFO operand stack, internal ALU and a capture/compute/write FSM.
// Optional signed saturation of ADD/SUB is enabled by defining RPN_SATURACAO_EN.
module calculadora_rpn_pilha #(
   parameter int unsigned LARGURA      = 8,
   parameter int unsigned PROFUNDIDADE = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LARGURA-1:0]                entrada_numero,
   input  logic                              push_pilha,
   input  logic                              executar_operacao,
   input  logic [2:0]                        codigo_operacao,
   output logic [LARGURA-1:0]                valor_exibicao,
   output logic [$clog2(PROFUNDIDADE+1)-1:0] nivel_pilha,
   output logic                              pilha_vazia,
   output logic                              pilha_cheia,
   output logic                              ocupado,
   output logic                              zero,
   output logic                              carry_out,
   output logic                              overflow,
   output logic                              erro
);

   localparam int unsigned NW = $clog2(PROFUNDIDADE + 1);
   localparam int unsigned M  = LARGURA - 1;
   localparam logic [LARGURA:0] UM = 1;

   typedef enum logic [1:0] {StOcioso, StLe, StEscreve} estado_t;

   estado_t estado_q, estado_d;

   logic [LARGURA-1:0] pilha_q [PROFUNDIDADE];
   logic [NW-1:0]      nivel_q;
   logic [2:0]         op_q;
   logic [LARGURA-1:0] tos_q, nos_q, res_q;
   logic               res_carry_q, res_ovf_q;
   logic               zero_q, carry_q, ovf_q, erro_q;

   logic [LARGURA-1:0] tos, nos;
   logic               cheia, ocioso, pre_ok;
   logic               push_ok, push_err, exec_ok, exec_err;
   logic [LARGURA:0]   soma, dif;
   logic [LARGURA-1:0] alu_res;
   logic               alu_c, alu_v;

   // TOS/NOS read muxes; both read as 0 when the slot is not valid
   always_comb begin
      tos = '0;
      nos = '0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
         if (i + 1 == int'(nivel_q)) tos = pilha_q[i];
         if (i + 2 == int'(nivel_q)) nos = pilha_q[i];
      end
   end

   assign cheia  = (nivel_q == NW'(PROFUNDIDADE));
   assign ocioso = (estado_q == StOcioso);

   always_comb begin
      pre_ok = 1'b0;
      case (codigo_operacao)
         3'b101:  pre_ok = (nivel_q != '0);
         3'b110:  pre_ok = (nivel_q != '0) && !cheia;
         default: pre_ok = (nivel_q >= NW'(2));
      endcase
   end

   // Push has priority; a simultaneous execute strobe is dropped
   assign push_ok  = ocioso && push_pilha && !cheia;
   assign push_err = ocioso && push_pilha && cheia;
   assign exec_ok  = ocioso && !push_pilha && executar_operacao && pre_ok;
   assign exec_err = ocioso && !push_pilha && executar_operacao && !pre_ok;

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         StOcioso:  if (exec_ok) estado_d = StLe;
         StLe:      estado_d = StEscreve;
         StEscreve: estado_d = StOcioso;
         default:   estado_d = StOcioso;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) estado_q <= StOcioso;
      else     estado_q <= estado_d;
   end

   assign soma = {1'b0, nos_q} + {1'b0, tos_q};
   assign dif  = {1'b0, nos_q} + {1'b0, ~tos_q} + UM;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         3'b000: begin
            alu_res = soma[M:0];
            alu_c   = soma[LARGURA];
            alu_v   = (nos_q[M] == tos_q[M]) && (soma[M] != nos_q[M]);
         end
         3'b001: begin
            alu_res = dif[M:0];
            alu_c   = dif[LARGURA];
            alu_v   = (nos_q[M] != tos_q[M]) && (dif[M] != nos_q[M]);
         end
         3'b010:  alu_res = nos_q & tos_q;
         3'b011:  alu_res = nos_q | tos_q;
         3'b100:  alu_res = nos_q ^ tos_q;
         3'b101:  alu_res = ~tos_q;
         default: alu_res = '0;
      endcase
`ifdef RPN_SATURACAO_EN
      // Overflow direction always follows the sign of NOS for both ADD and SUB
      if (alu_v) alu_res = nos_q[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nivel_q <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            for (int i = 0; i < PROFUNDIDADE; i++)
               if (i == int'(nivel_q)) pilha_q[i] <= entrada_numero;
            nivel_q <= nivel_q + NW'(1);
            erro_q  <= 1'b0;
         end
         if (push_err || exec_err) erro_q <= 1'b1;
         if (exec_ok) begin
            op_q  <= codigo_operacao;
            tos_q <= tos;
            nos_q <= nos;
         end
         if (estado_q == StLe) begin
            res_q       <= alu_res;
            res_carry_q <= alu_c;
            res_ovf_q   <= alu_v;
         end
         if (estado_q == StEscreve) begin
            erro_q <= 1'b0;
            case (op_q)
               3'b101: begin
                  for (int i = 0; i < PROFUNDIDADE; i++)
                     if (i == int'(nivel_q) - 1) pilha_q[i] <= res_q;
               end
               3'b110: begin
                  for (int i = 0; i < PROFUNDIDADE; i++)
                     if (i == int'(nivel_q)) pilha_q[i] <= tos_q;
                  nivel_q <= nivel_q + NW'(1);
               end
               3'b111: begin
                  for (int i = 0; i < PROFUNDIDADE; i++) begin
                     if (i == int'(nivel_q) - 1) pilha_q[i] <= nos_q;
                     if (i == int'(nivel_q) - 2) pilha_q[i] <= tos_q;
                  end
               end
               default: begin
                  for (int i = 0; i < PROFUNDIDADE; i++)
                     if (i == int'(nivel_q) - 2) pilha_q[i] <= res_q;
                  nivel_q <= nivel_q - NW'(1);
               end
            endcase
            if (op_q <= 3'b101) begin
               zero_q  <= (res_q == '0);
               carry_q <= res_carry_q;
               ovf_q   <= res_ovf_q;
            end
         end
      end
   end

   assign valor_exibicao = tos;
   assign nivel_pilha    = nivel_q;
   assign pilha_vazia    = (nivel_q == '0);
   assign pilha_cheia    = cheia;
   assign ocupado        = !ocioso;
   assign zero           = zero_q;
   assign carry_out      = carry_q;
   assign overflow       = ovf_q;
   assign erro           = erro_q;

endmodule

// File: tb/tb_calculadora_rpn_pilha.sv
// Directed self-checking bench for calculadora_rpn_pilha (LARGURA=8, PROFUNDIDADE=4).
module tb_calculadora_rpn_pilha;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] entrada_numero = '0;
   logic       push_pilha = 1'b0;
   logic       executar_operacao = 1'b0;
   logic [2:0] codigo_operacao = '0;
   logic [7:0] valor_exibicao;
   logic [2:0] nivel_pilha;
   logic       pilha_vazia, pilha_cheia, ocupado, zero, carry_out, overflow, erro;

   int n_chk  = 0;
   int n_fail = 0;

   calculadora_rpn_pilha #(.LARGURA(8), .PROFUNDIDADE(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .entrada_numero    (entrada_numero),
      .push_pilha        (push_pilha),
      .executar_operacao (executar_operacao),
      .codigo_operacao   (codigo_operacao),
      .valor_exibicao    (valor_exibicao),
      .nivel_pilha       (nivel_pilha),
      .pilha_vazia       (pilha_vazia),
      .pilha_cheia       (pilha_cheia),
      .ocupado           (ocupado),
      .zero              (zero),
      .carry_out         (carry_out),
      .overflow          (overflow),
      .erro              (erro)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      entrada_numero = v;
      push_pilha     = 1'b1;
      tick();
      push_pilha     = 1'b0;
   endtask

   // Accepted execute; strobes and a changed opcode are held during busy cycles and must be ignored
   task automatic exec(input logic [2:0] c, input string tag);
      codigo_operacao   = c;
      executar_operacao = 1'b1;
      tick();
      chk({tag, "_busy1"}, ocupado, 1);
      codigo_operacao = ~c;
      push_pilha      = 1'b1;
      entrada_numero  = 8'h55;
      tick();
      chk({tag, "_busy2"}, ocupado, 1);
      tick();
      push_pilha        = 1'b0;
      executar_operacao = 1'b0;
      chk({tag, "_done"}, ocupado, 0);
      chk({tag, "_erro"}, erro, 0);
   endtask

   task automatic exec_rej(input logic [2:0] c, input string tag);
      codigo_operacao   = c;
      executar_operacao = 1'b1;
      tick();
      executar_operacao = 1'b0;
      chk({tag, "_erro"}, erro, 1);
      chk({tag, "_ocup"}, ocupado, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_nivel", nivel_pilha, 0);
      chk("rst_vazia", pilha_vazia, 1);
      chk("rst_cheia", pilha_cheia, 0);
      chk("rst_ocup", ocupado, 0);
      chk("rst_valor", valor_exibicao, 0);
      chk("rst_flags", {zero, carry_out, overflow, erro}, 4'b0000);

      // 5 + 3
      push(8'h05);
      push(8'h03);
      chk("push_nivel", nivel_pilha, 2);
      chk("push_tos", valor_exibicao, 8'h03);
      exec(3'b000, "add");
      chk("add_valor", valor_exibicao, 8'h08);
      chk("add_nivel", nivel_pilha, 1);
      chk("add_flags", {zero, carry_out, overflow}, 3'b000);

      // 3 - 5 borrows; 7F + 01 overflows
      do_reset();
      push(8'h03);
      push(8'h05);
      exec(3'b001, "sub");
      chk("sub_valor", valor_exibicao, 8'hFE);
      chk("sub_flags", {zero, carry_out, overflow}, 3'b000);
      push(8'h7F);
      push(8'h01);
      exec(3'b000, "addov");
`ifdef RPN_SATURACAO_EN
      chk("addov_valor", valor_exibicao, 8'h7F);
`else
      chk("addov_valor", valor_exibicao, 8'h80);
`endif
      chk("addov_flags", {zero, carry_out, overflow}, 3'b001);
      chk("addov_nivel", nivel_pilha, 2);

      // Full stack
      do_reset();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      chk("full_cheia", pilha_cheia, 1);
      chk("full_nivel", nivel_pilha, 4);
      push(8'h05);
      chk("ovpush_erro", erro, 1);
      chk("ovpush_tos", valor_exibicao, 8'h04);
      chk("ovpush_nivel", nivel_pilha, 4);
      exec_rej(3'b110, "dupfull");
      tick();
      chk("dupfull_tos", valor_exibicao, 8'h04);
      chk("dupfull_nivel", nivel_pilha, 4);
      chk("dupfull_erro_sticky", erro, 1);
      exec(3'b000, "pop");
      chk("pop_valor", valor_exibicao, 8'h07);
      chk("pop_nivel", nivel_pilha, 3);
      push(8'h09);
      chk("push9_erro", erro, 0);
      chk("push9_tos", valor_exibicao, 8'h09);

      // Empty stack, unary NOT, SWAP underflow
      do_reset();
      exec_rej(3'b000, "addempty");
      tick();
      chk("addempty_ocup", ocupado, 0);
      chk("addempty_nivel", nivel_pilha, 0);
      push(8'h0F);
      chk("pushclr_erro", erro, 0);
      exec(3'b101, "not");
      chk("not_valor", valor_exibicao, 8'hF0);
      chk("not_nivel", nivel_pilha, 1);
      chk("not_flags", {zero, carry_out, overflow}, 3'b000);
      exec_rej(3'b111, "swap1");
      chk("swap1_tos", valor_exibicao, 8'hF0);

      // FF + 01 sets zero and carry; SWAP and DUP must keep them
      do_reset();
      push(8'hFF);
      push(8'h01);
      exec(3'b000, "addz");
      chk("addz_valor", valor_exibicao, 8'h00);
      chk("addz_flags", {zero, carry_out, overflow}, 3'b110);
      push(8'h0A);
      push(8'h0B);
      exec(3'b111, "swap");
      chk("swap_tos", valor_exibicao, 8'h0A);
      chk("swap_nivel", nivel_pilha, 3);
      chk("swap_flags", {zero, carry_out, overflow}, 3'b110);
      exec(3'b001, "subswap");
      chk("subswap_valor", valor_exibicao, 8'h01);
      chk("subswap_flags", {zero, carry_out, overflow}, 3'b010);
      exec(3'b110, "dup");
      chk("dup_valor", valor_exibicao, 8'h01);
      chk("dup_nivel", nivel_pilha, 3);
      chk("dup_flags", {zero, carry_out, overflow}, 3'b010);

      // Push and execute together: push wins
      entrada_numero    = 8'h22;
      codigo_operacao   = 3'b000;
      push_pilha        = 1'b1;
      executar_operacao = 1'b1;
      tick();
      push_pilha        = 1'b0;
      executar_operacao = 1'b0;
      chk("both_tos", valor_exibicao, 8'h22);
      chk("both_nivel", nivel_pilha, 4);
      chk("both_ocup", ocupado, 0);
      tick();
      chk("both_tos2", valor_exibicao, 8'h22);
      chk("both_ocup2", ocupado, 0);

      // Reset during LE aborts with no writeback
      codigo_operacao   = 3'b000;
      executar_operacao = 1'b1;
      tick();
      executar_operacao = 1'b0;
      chk("abort_busy", ocupado, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_nivel", nivel_pilha, 0);
      chk("abort_valor", valor_exibicao, 0);
      chk("abort_vazia", pilha_vazia, 1);
      chk("abort_ocup", ocupado, 0);
      chk("abort_flags", {zero, carry_out, overflow, erro}, 4'b0000);
      tick();
      tick();
      chk("abort_nivel2", nivel_pilha, 0);
      chk("abort_ocup2", ocupado, 0);
      push(8'h42);
      chk("after_tos", valor_exibicao, 8'h42);
      chk("after_nivel", nivel_pilha, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
